// File: rtl/cic_decimator_mc.sv
// cic_decimator_mc
// Multi-channel, time-multiplexed CIC decimator with a runtime power-of-two
// ratio. One shared integrator/comb datapath serves every channel. The
// per-channel integrators, counters and comb delays live in register arrays.
// A channel tag travels with each sample down the comb pipeline.
// Optional build macro CIC_ROUND_EN: round half up before the final shift.
// Without it the final shift truncates (floor).
module cic_decimator_mc #(
   parameter int  IN_W       = 16,
   parameter int  STAGES     = 4,
   parameter int  MAX_LOG2_R = 6,
   parameter int  CHANNELS   = 2,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int ACC_W      = IN_W + STAGES * MAX_LOG2_R,
   localparam int DL_W       = $clog2(MAX_LOG2_R + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_in,
   input  logic [CH_W-1:0]        chan_in,
   input  logic signed [IN_W-1:0] din,
   input  logic [DL_W-1:0]        dec_log2,
   output logic                   valid_out,
   output logic [CH_W-1:0]        chan_out,
   output logic signed [IN_W-1:0] dout,
   output logic                   ovf
);

   localparam int CNT_W = MAX_LOG2_R;
   localparam int RW    = MAX_LOG2_R + 1;
   localparam int CHL_W = CH_W + 1;
   localparam int SH_W  = $clog2(STAGES * MAX_LOG2_R + 1);

   typedef logic signed [ACC_W-1:0] acc_t;

   localparam logic [CHL_W-1:0] CH_LIMIT = CHL_W'(CHANNELS);
   localparam acc_t SAT_MAX = {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
   localparam acc_t SAT_MIN = {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

   // Active ratio
   logic [DL_W-1:0]  dl_act_q, dl_act_d;

   // Per-channel integrator cascade and decimation counter
   acc_t             integ_q [CHANNELS][STAGES];
   acc_t             integ_d [CHANNELS][STAGES];
   logic [CNT_W-1:0] cnt_q   [CHANNELS];
   logic [CNT_W-1:0] cnt_d   [CHANNELS];

   // Comb pipeline: index 0 is the push register, index s the output of comb stage s
   logic             stg_vld_q [STAGES+1];
   logic             stg_vld_d [STAGES+1];
   logic [CH_W-1:0]  stg_ch_q  [STAGES+1];
   logic [CH_W-1:0]  stg_ch_d  [STAGES+1];
   acc_t             stg_dat_q [STAGES+1];
   acc_t             stg_dat_d [STAGES+1];
   acc_t             dly_q     [STAGES][CHANNELS];
   acc_t             dly_d     [STAGES][CHANNELS];

   // Output register
   logic                   valid_out_q, valid_out_d;
   logic [CH_W-1:0]        chan_out_q,  chan_out_d;
   logic signed [IN_W-1:0] dout_q,      dout_d;
   logic                   ovf_q,       ovf_d;

   // Combinational helpers
   logic [DL_W-1:0]  dl_clamped;
   logic             ratio_chg;
   logic             ch_ok;
   logic [CH_W-1:0]  ch_idx;
   logic             accept;
   logic             push;
   logic [RW-1:0]    r_full;
   logic [RW-1:0]    r_last;
   logic [SH_W-1:0]  sh;
   acc_t             din_ext;
   acc_t             integ_new [STAGES];
   acc_t             comb_out;
   acc_t             rnd;
   acc_t             scaled;
   logic signed [IN_W-1:0] sat_val;
   logic             sat_hit;

   // Ratio clamp, ratio-change detect, input acceptance and push decision
   always_comb begin
      // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
      dl_clamped = dec_log2;
      if (dec_log2 == '0) begin
         dl_clamped = DL_W'(1);
      end else if (dec_log2 > DL_W'(MAX_LOG2_R)) begin
         dl_clamped = DL_W'(MAX_LOG2_R);
      end
      ratio_chg = (dl_clamped != dl_act_q);
      dl_act_d  = dl_clamped;

      // Out-of-range channels are dropped; the safe index keeps array reads in bounds
      ch_ok  = ({1'b0, chan_in} < CH_LIMIT);
      ch_idx = ch_ok ? chan_in : '0;
      accept = valid_in && ch_ok && !ratio_chg;

      // The R-th accepted sample of a channel (counter == R-1) is pushed into the comb
      r_full = RW'(1) << dl_act_q;
      r_last = r_full - RW'(1);
      push   = accept && ({1'b0, cnt_q[ch_idx]} == r_last);

      sh = SH_W'(STAGES) * SH_W'(dl_act_q);
   end

   // Integrator cascade and decimation counter of the addressed channel
   always_comb begin
      integ_d = integ_q;
      cnt_d   = cnt_q;
      din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

      // Stages chain combinationally: the pushed value already includes this sample
      integ_new[0] = integ_q[ch_idx][0] + din_ext;
      for (int s = 1; s < STAGES; s++) begin
         integ_new[s] = integ_q[ch_idx][s] + integ_new[s-1];
      end

      if (accept) begin
         for (int s = 0; s < STAGES; s++) begin
            integ_d[ch_idx][s] = integ_new[s];
         end
         cnt_d[ch_idx] = push ? '0 : cnt_q[ch_idx] + CNT_W'(1);
      end

      // A ratio change restarts every channel from zero history
      if (ratio_chg) begin
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = '0;
            for (int s = 0; s < STAGES; s++) begin
               integ_d[c][s] = '0;
            end
         end
      end
   end

   // Comb pipeline: each stage subtracts its per-channel delay selected by the travelling tag
   always_comb begin
      dly_d = dly_q;

      stg_vld_d[0] = push;
      stg_ch_d[0]  = ch_idx;
      stg_dat_d[0] = integ_new[STAGES-1];

      for (int s = 1; s <= STAGES; s++) begin
         stg_vld_d[s] = stg_vld_q[s-1];
         stg_ch_d[s]  = stg_ch_q[s-1];
         stg_dat_d[s] = stg_dat_q[s-1] - dly_q[s-1][stg_ch_q[s-1]];
         if (stg_vld_q[s-1]) begin
            dly_d[s-1][stg_ch_q[s-1]] = stg_dat_q[s-1];
         end
      end

      if (ratio_chg) begin
         for (int s = 0; s <= STAGES; s++) begin
            stg_vld_d[s] = 1'b0;
         end
         for (int s = 0; s < STAGES; s++) begin
            for (int c = 0; c < CHANNELS; c++) begin
               dly_d[s][c] = '0;
            end
         end
      end
   end

   // Gain normalisation (arithmetic shift by STAGES*log2 R), saturation and output capture
   always_comb begin
      comb_out = stg_dat_q[STAGES];
      rnd      = '0;
`ifdef CIC_ROUND_EN
      rnd      = acc_t'(1) <<< (sh - SH_W'(1));
`endif
      scaled   = (comb_out + rnd) >>> sh;

      sat_hit = 1'b0;
      sat_val = scaled[IN_W-1:0];
      if (scaled > SAT_MAX) begin
         sat_hit = 1'b1;
         sat_val = SAT_MAX[IN_W-1:0];
      end else if (scaled < SAT_MIN) begin
         sat_hit = 1'b1;
         sat_val = SAT_MIN[IN_W-1:0];
      end

      valid_out_d = stg_vld_q[STAGES] && !ratio_chg;
      chan_out_d  = chan_out_q;
      dout_d      = dout_q;
      ovf_d       = ovf_q;
      if (valid_out_d) begin
         chan_out_d = stg_ch_q[STAGES];
         dout_d     = sat_val;
         ovf_d      = ovf_q | sat_hit;
      end
   end

   // Ratio register: reset loads the (clamped) requested ratio
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (rst) begin
         dl_act_q <= dl_clamped;
      end else begin
         dl_act_q <= dl_act_d;
      end
   end

   // Per-channel integrator and counter arrays
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: these arrays are reset explicitly because a restart must begin from zero history.
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c] <= '0;
            for (int s = 0; s < STAGES; s++) begin
               integ_q[c][s] <= '0;
            end
         end
      end else begin
         integ_q <= integ_d;
         cnt_q   <= cnt_d;
      end
   end

   // Comb pipeline registers and per-stage delay arrays
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s <= STAGES; s++) begin
            stg_vld_q[s] <= 1'b0;
            stg_ch_q[s]  <= '0;
            stg_dat_q[s] <= '0;
         end
         for (int s = 0; s < STAGES; s++) begin
            for (int c = 0; c < CHANNELS; c++) begin
               dly_q[s][c] <= '0;
            end
         end
      end else begin
         stg_vld_q <= stg_vld_d;
         stg_ch_q  <= stg_ch_d;
         stg_dat_q <= stg_dat_d;
         dly_q     <= dly_d;
      end
   end

   // Output register and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out_q <= 1'b0;
         chan_out_q  <= '0;
         dout_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         valid_out_q <= valid_out_d;
         chan_out_q  <= chan_out_d;
         dout_q      <= dout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign valid_out = valid_out_q;
   assign chan_out  = chan_out_q;
   assign dout      = dout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cic_decimator_mc.sv
// tb_cic_decimator_mc
// Directed bench for cic_decimator_mc. A reference model computes each output
// as the direct convolution of the channel's accepted-sample history with the
// coefficients of ((1 - z^-R)/(1 - z^-1))^STAGES, then scales and saturates.
// A second instance with three channels exercises dropping of out-of-range
// channel numbers. Honours CIC_ROUND_EN for the expected values.
module tb_cic_decimator_mc;

   localparam int IN_W     = 16;
   localparam int STAGES   = 4;
   localparam int MAX_L    = 6;
   localparam int CHANNELS = 2;

`ifdef CIC_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   // Hand-computed step-response values
   localparam longint T1_FIRST = ROUND ? 81 : 80;    // 1000*330/4096
   localparam longint T4_STEADY = ROUND ? 1 : 0;     // 8/16
   localparam longint T5_FIRST = ROUND ? 137 : 136;  // 1000*35/256
   localparam longint T6_SECOND = 624;               // 1000*2556/4096

   logic                   clk;
   logic                   rst;
   logic                   valid_in;
   logic [0:0]             chan_in;
   logic signed [IN_W-1:0] din;
   logic [2:0]             dec_log2;
   logic                   valid_out;
   logic [0:0]             chan_out;
   logic signed [IN_W-1:0] dout;
   logic                   ovf;

   logic                   valid_in3;
   logic [1:0]             chan_in3;
   logic                   valid_out3;
   logic [1:0]             chan_out3;
   logic signed [IN_W-1:0] dout3;
   logic                   ovf3;

   cic_decimator_mc #(
      .IN_W(IN_W), .STAGES(STAGES), .MAX_LOG2_R(MAX_L), .CHANNELS(CHANNELS)
   ) u_dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .chan_in(chan_in), .din(din),
      .dec_log2(dec_log2), .valid_out(valid_out), .chan_out(chan_out),
      .dout(dout), .ovf(ovf)
   );

   cic_decimator_mc #(
      .IN_W(IN_W), .STAGES(STAGES), .MAX_LOG2_R(MAX_L), .CHANNELS(3)
   ) u_dut3 (
      .clk(clk), .rst(rst), .valid_in(valid_in3), .chan_in(chan_in3), .din(din),
      .dec_log2(dec_log2), .valid_out(valid_out3), .chan_out(chan_out3),
      .dout(dout3), .ovf(ovf3)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int     due;
      int     ch;
      longint val;
   } exp_t;

   exp_t   exp_q[$];
   longint coef [0:255];
   int     coef_len;
   longint hist [0:CHANNELS-1][0:255];
   int     m_cnt [0:CHANNELS-1];
   int     m_dl;
   int     cyc = 0;
   bit     started = 1'b0;
   longint m_last_val = 0;

   function automatic int clamp_dl(input int d);
      if (d == 0) return 1;
      if (d > MAX_L) return MAX_L;
      return d;
   endfunction

   // Coefficients of (1 + z + ... + z^(R-1))^STAGES by repeated convolution
   task automatic build_coef(input int dl);
      longint nxt [0:255];
      int r;
      r = 1 << dl;
      for (int i = 0; i < 256; i++) coef[i] = 0;
      coef[0]  = 1;
      coef_len = 1;
      repeat (STAGES) begin
         for (int n = 0; n < 256; n++) nxt[n] = 0;
         for (int n = 0; n < coef_len + r - 1; n++) begin
            for (int j = 0; j < r; j++) begin
               if (n - j >= 0 && n - j < coef_len) nxt[n] += coef[n-j];
            end
         end
         coef_len += r - 1;
         for (int n = 0; n < 256; n++) coef[n] = nxt[n];
      end
   endtask

   task automatic model_restart(input int dl);
      m_dl = dl;
      build_coef(dl);
      for (int c = 0; c < CHANNELS; c++) begin
         m_cnt[c] = 0;
         for (int k = 0; k < 256; k++) hist[c][k] = 0;
      end
      exp_q.delete();
   endtask

   always @(posedge clk) begin : model
      int     d;
      int     ch;
      int     sh;
      longint acc;
      longint q;
      d = clamp_dl(int'(dec_log2));
      cyc++;
      if (rst) begin
         started = 1'b1;
         model_restart(d);
      end else if (started) begin
         if (d != m_dl) begin
            model_restart(d);
         end else if (valid_in && int'(chan_in) < CHANNELS) begin
            ch = int'(chan_in);
            for (int k = 255; k > 0; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = longint'(din);
            m_cnt[ch]++;
            if (m_cnt[ch] == (1 << m_dl)) begin
               m_cnt[ch] = 0;
               acc = 0;
               for (int k = 0; k < coef_len; k++) acc += coef[k] * hist[ch][k];
               sh = STAGES * m_dl;
               if (ROUND) acc += longint'(1) <<< (sh - 1);
               q = acc >>> sh;
               if (q > 32767) q = 32767;
               else if (q < -32768) q = -32768;
               exp_q.push_back('{due: cyc + STAGES + 1, ch: ch, val: q});
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int     n_strobe [0:CHANNELS-1];
   longint last_out [0:CHANNELS-1];

   always @(negedge clk) begin : compare
      exp_t e;
      if (started) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            m_last_val = e.val;
            check("strobe_valid", valid_out, 1);
            check("strobe_chan", chan_out, e.ch);
            check("strobe_dout", dout, e.val);
         end else begin
            check("idle_valid", valid_out, 0);
         end
         if (valid_out === 1'b1) begin
            n_strobe[chan_out]++;
            last_out[chan_out] = dout;
         end
      end
   end

   // Strobes of the three-channel instance during the drop test
   bit     col_en = 1'b0;
   int     col_ch[$];
   longint col_val[$];

   always @(negedge clk) begin
      if (col_en && valid_out3 === 1'b1) begin
         col_ch.push_back(int'(chan_out3));
         col_val.push_back(longint'(dout3));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input int d);
      valid_in = 1'b1;
      chan_in  = 1'(ch);
      din      = 16'(d);
      tick();
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic pulse_rst(input int dl);
      dec_log2 = 3'(dl);
      valid_in = 1'b0;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
   endtask

   task automatic drive3(input int ch, input int d);
      valid_in3 = 1'b1;
      chan_in3  = 2'(ch);
      din       = 16'(d);
      tick();
   endtask

   int snap;

   initial begin
      clk = 1'b0; rst = 1'b1; valid_in = 1'b0; chan_in = '0; din = '0;
      dec_log2 = 3'd3; valid_in3 = 1'b0; chan_in3 = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         n_strobe[c] = 0;
         last_out[c] = 0;
      end
      tick();
      check("rst_valid_out", valid_out, 0);
      check("rst_chan_out", chan_out, 0);
      check("rst_dout", dout, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;

      // 1: R=8, constant 1000 on channel 0; first strobe STAGES+1 cycles after 8th sample
      for (int i = 0; i < 8; i++) drive(0, 1000);
      valid_in = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 4) check("t1_lat_early", valid_out, 0);
         if (i == 5) begin
            check("t1_lat", valid_out, 1);
            check("t1_first_dout", dout, T1_FIRST);
         end
      end
      tick();
      check("t1_model_first", m_last_val, T1_FIRST);
      for (int i = 0; i < 40; i++) drive(0, 1000);
      idle(8);
      check("t1_settled", last_out[0], 1000);

      // 2: two channels alternating, independent counts
      pulse_rst(3);
      for (int c = 0; c < CHANNELS; c++) n_strobe[c] = 0;
      for (int i = 0; i < 80; i++) drive(i % 2, (i % 2) ? -500 : 1000);
      idle(8);
      check("t2_settled_ch0", last_out[0], 1000);
      check("t2_settled_ch1", last_out[1], -500);
      check("t2_count_ch0", n_strobe[0], 5);
      check("t2_count_ch1", n_strobe[1], 5);

      // 3: full-scale inputs at the largest ratio (requested 7, clamped to 6)
      pulse_rst(7);
      for (int i = 0; i < 400; i++) drive(0, 32767);
      check("t3_pos_full", last_out[0], 32767);
      for (int i = 0; i < 400; i++) drive(0, -32768);
      idle(8);
      check("t3_neg_full", last_out[0], -32768);
      check("t3_ovf", ovf, 0);

      // 4: smallest ratio (requested 0, clamped to 1), alternating 0/1
      pulse_rst(0);
      for (int i = 0; i < 40; i++) drive(0, i % 2);
      idle(8);
      check("t4_steady", last_out[0], T4_STEADY);

      // 5: ratio change 3 -> 2 mid-stream flushes in-flight data
      pulse_rst(3);
      for (int i = 0; i < 20; i++) drive(0, 1000);
      snap = n_strobe[0];
      dec_log2 = 3'd2;
      drive(0, 1000);
      for (int i = 0; i < 4; i++) drive(0, 1000);
      valid_in = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 4) check("t5_lat_early", valid_out, 0);
         if (i == 5) begin
            check("t5_no_stale", n_strobe[0], snap);
            check("t5_lat", valid_out, 1);
            check("t5_first_dout", dout, T5_FIRST);
         end
      end
      idle(3);

      // 6: reset in the cycle a strobe is due, then out-of-range channel drop
      pulse_rst(3);
      for (int i = 0; i < 12; i++) drive(0, 1000);
      rst = 1'b1;
      valid_in = 1'b1;
      tick();
      rst = 1'b0;
      valid_in = 1'b0;
      check("t6_rst_valid_out", valid_out, 0);
      check("t6_rst_chan_out", chan_out, 0);
      check("t6_rst_dout", dout, 0);
      check("t6_rst_ovf", ovf, 0);

      col_en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i % 2 == 0) drive3(0, 1000);
         else drive3(3, 30000);
      end
      valid_in3 = 1'b0;
      repeat (10) tick();
      col_en = 1'b0;
      check("t6_drop_count", col_val.size(), 2);
      if (col_val.size() >= 2) begin
         check("t6_first_dout", col_val[0], T1_FIRST);
         check("t6_second_dout", col_val[1], T6_SECOND);
         check("t6_first_chan", col_ch[0], 0);
         check("t6_second_chan", col_ch[1], 0);
      end
      check("t6_ovf3", ovf3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
